// File: rtl/m_wbarbiter_pkg.sv
// Shared Wishbone bus dimensions for the two-master arbiter slice.
package m_wbarbiter_pkg;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
endpackage

// File: rtl/m_wbarbiter_wbtimeout.sv
// Bus-timeout counter: counts stalled strobe cycles, flags expiry for one cycle.
module m_wbtimeout #(
  parameter int unsigned TOBITS = 4
) (
  input  logic CLK_I,
  input  logic RST_I,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  logic [TOBITS-1:0] r_cnt;

  assign expired = inc && (r_cnt == '1);

  always_ff @(posedge CLK_I) begin
    if (!RST_I || clr || expired) r_cnt <= '0;
    else if (inc)                 r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/m_wbarbiter.sv
// Two-master Wishbone arbiter with bus locking, alternating tie-break and
// per-transfer timeout error.
module m_wbarbiter
  import m_wbarbiter_pkg::*;
#(
  parameter int unsigned TOBITS   = 4,
  parameter bit          FIRSTWIN = 1'b0
) (
  input  logic          CLK_I,
  input  logic          RST_I,
  input  logic          m0_CYC_I,
  input  logic          m0_STB_I,
  input  logic          m0_WE_I,
  input  logic [AW-1:0] m0_ADR_I,
  input  logic [DW-1:0] m0_DAT_I,
  input  logic [SW-1:0] m0_SEL_I,
  output logic          m0_ACK_O,
  output logic          m0_ERR_O,
  input  logic          m1_CYC_I,
  input  logic          m1_STB_I,
  input  logic          m1_WE_I,
  input  logic [AW-1:0] m1_ADR_I,
  input  logic [DW-1:0] m1_DAT_I,
  input  logic [SW-1:0] m1_SEL_I,
  output logic          m1_ACK_O,
  output logic          m1_ERR_O,
  output logic          CYC_O,
  output logic          STB_O,
  output logic          WE_O,
  output logic [AW-1:0] ADR_O,
  output logic [DW-1:0] DAT_O,
  output logic [SW-1:0] SEL_O,
  input  logic [DW-1:0] DAT_I,
  input  logic          ACK_I,
  output logic [DW-1:0] mDAT_O,
  output logic [1:0]    grant
);
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } state_t;

  state_t r_state;
  logic   r_lastsrv;
  logic   w_g0, w_g1, w_inc, w_expired;

  assign w_g0  = (r_state == GNT0);
  assign w_g1  = (r_state == GNT1);
  assign grant = r_state;

  always_ff @(posedge CLK_I) begin
    if (!RST_I) begin
      r_state   <= IDLE;
      r_lastsrv <= ~FIRSTWIN;
    end else begin
      case (r_state)
        IDLE: begin
          if (m0_CYC_I && m1_CYC_I) r_state <= r_lastsrv ? GNT0 : GNT1;
          else if (m0_CYC_I)        r_state <= GNT0;
          else if (m1_CYC_I)        r_state <= GNT1;
        end
        GNT0: if (!m0_CYC_I) begin
          r_lastsrv <= 1'b0;
          r_state   <= m1_CYC_I ? GNT1 : IDLE;
        end
        GNT1: if (!m1_CYC_I) begin
          r_lastsrv <= 1'b1;
          r_state   <= m0_CYC_I ? GNT0 : IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    CYC_O    = 1'b0;
    STB_O    = 1'b0;
    WE_O     = 1'b0;
    ADR_O    = '0;
    DAT_O    = '0;
    SEL_O    = '0;
    m0_ACK_O = 1'b0;
    m1_ACK_O = 1'b0;
    if (w_g0) begin
      CYC_O    = m0_CYC_I;
      STB_O    = m0_STB_I;
      WE_O     = m0_WE_I;
      ADR_O    = m0_ADR_I;
      DAT_O    = m0_DAT_I;
      SEL_O    = m0_SEL_I;
      m0_ACK_O = ACK_I;
    end else if (w_g1) begin
      CYC_O    = m1_CYC_I;
      STB_O    = m1_STB_I;
      WE_O     = m1_WE_I;
      ADR_O    = m1_ADR_I;
      DAT_O    = m1_DAT_I;
      SEL_O    = m1_SEL_I;
      m1_ACK_O = ACK_I;
    end
  end

  assign mDAT_O = DAT_I;

  // Stall detect is built from master inputs, not the muxed bus, so the
  // error path has no dependence on the output mux; reset masks it too.
  assign w_inc = RST_I && !ACK_I &&
                 ((w_g0 && m0_CYC_I && m0_STB_I) || (w_g1 && m1_CYC_I && m1_STB_I));

  m_wbtimeout #(.TOBITS(TOBITS)) u_timeout (
    .CLK_I  (CLK_I),
    .RST_I  (RST_I),
    .clr    (!w_inc),
    .inc    (w_inc),
    .expired(w_expired)
  );

  assign m0_ERR_O = w_g0 && w_expired;
  assign m1_ERR_O = w_g1 && w_expired;
endmodule

// File: tb/tb_m_wbarbiter.sv
// Directed bench for m_wbarbiter: stimulus queues expected master responses,
// a negedge monitor compares them as the arbiter presents ACK/ERR.
module tb_m_wbarbiter;
  logic        clk, rst_n;
  logic        m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat, s_dat;
  logic [3:0]  m0_sel, m1_sel;
  logic        ack;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic        cyc_o, stb_o, we_o;
  logic [31:0] adr_o, dat_o, mdat;
  logic [3:0]  sel_o;
  logic [1:0]  grant;

  typedef struct {
    int unsigned cyc;
    logic        a0, e0, a1, e1;
    logic [31:0] dat;
  } ev_t;

  ev_t         q[$];
  ev_t         e;
  int unsigned cyc = 0;
  int          ncomp = 0;
  int          nfail = 0;
  int unsigned g;

  m_wbarbiter #(.TOBITS(4), .FIRSTWIN(1'b0)) dut (
    .CLK_I(clk), .RST_I(rst_n),
    .m0_CYC_I(m0_cyc), .m0_STB_I(m0_stb), .m0_WE_I(m0_we),
    .m0_ADR_I(m0_adr), .m0_DAT_I(m0_dat), .m0_SEL_I(m0_sel),
    .m0_ACK_O(m0_ack), .m0_ERR_O(m0_err),
    .m1_CYC_I(m1_cyc), .m1_STB_I(m1_stb), .m1_WE_I(m1_we),
    .m1_ADR_I(m1_adr), .m1_DAT_I(m1_dat), .m1_SEL_I(m1_sel),
    .m1_ACK_O(m1_ack), .m1_ERR_O(m1_err),
    .CYC_O(cyc_o), .STB_O(stb_o), .WE_O(we_o),
    .ADR_O(adr_o), .DAT_O(dat_o), .SEL_O(sel_o),
    .DAT_I(s_dat), .ACK_I(ack), .mDAT_O(mdat), .grant(grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    ncomp++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input logic a0, input logic e0, input logic a1, input logic e1,
                           input int unsigned c, input logic [31:0] d);
    ev_t t;
    t.cyc = c; t.a0 = a0; t.e0 = e0; t.a1 = a1; t.e1 = e1; t.dat = d;
    q.push_back(t);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    chk("reset_grant", {30'd0, grant}, 32'd0);
    chk("reset_cyc", {31'd0, cyc_o}, 32'd0);
    rst_n = 1'b1;
  endtask

  // Response monitor: one comparison per presented ACK/ERR, plus missed ones.
  always @(negedge clk) begin
    if (q.size() != 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      ncomp++;
      nfail++;
      $display("FAIL missed_resp: got nothing at cycle %0d required a0=%b e0=%b a1=%b e1=%b",
               e.cyc, e.a0, e.e0, e.a1, e.e1);
    end
    if (m0_ack || m0_err || m1_ack || m1_err) begin
      ncomp++;
      if (q.size() == 0) begin
        nfail++;
        $display("FAIL unexpected_resp: got a0=%b e0=%b a1=%b e1=%b at cycle %0d required none",
                 m0_ack, m0_err, m1_ack, m1_err, cyc);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.a0 !== m0_ack || e.e0 !== m0_err || e.a1 !== m1_ack ||
            e.e1 !== m1_err || e.dat !== mdat) begin
          nfail++;
          $display("FAIL resp: got cyc=%0d a0=%b e0=%b a1=%b e1=%b dat=%0h required cyc=%0d a0=%b e0=%b a1=%b e1=%b dat=%0h",
                   cyc, m0_ack, m0_err, m1_ack, m1_err, mdat,
                   e.cyc, e.a0, e.e0, e.a1, e.e1, e.dat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; ack = 1'b0; s_dat = '0;
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_dat = '0; m0_sel = '0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_dat = '0; m1_sel = '0;
    do_reset();

    // Single m0 read, slave ACKs two cycles after CYC rises
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h100; m0_sel = 4'hf;
    #0;
    chk("idle_grant", {30'd0, grant}, 32'd0);
    chk("idle_cyc_o", {31'd0, cyc_o}, 32'd0);
    chk("idle_adr_o", adr_o, 32'd0);
    step();
    chk("a_grant", {30'd0, grant}, 32'd1);
    chk("a_adr_o", adr_o, 32'h100);
    chk("a_sel_o", {28'd0, sel_o}, 32'hf);
    step();
    ack = 1'b1; s_dat = 32'hCAFE0001;
    expect_ev(1'b1, 1'b0, 1'b0, 1'b0, cyc, 32'hCAFE0001);
    step();
    ack = 1'b0; s_dat = '0; m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
    chk("a_release", {30'd0, grant}, 32'd0);

    do_reset();

    // Tie from reset: m0 first, then m1 with no idle gap
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h200;
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 32'h300; m1_dat = 32'h1111_2222;
    step();
    chk("b_tie_grant", {30'd0, grant}, 32'd1);
    chk("b_adr0", adr_o, 32'h200);
    ack = 1'b1; s_dat = 32'h0000_00B0;
    expect_ev(1'b1, 1'b0, 1'b0, 1'b0, cyc, 32'h0000_00B0);
    step();
    ack = 1'b0; s_dat = '0; m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
    chk("b_handover", {30'd0, grant}, 32'd2);
    chk("b_adr1", adr_o, 32'h300);
    chk("b_we1", {31'd0, we_o}, 32'd1);
    chk("b_dat1", dat_o, 32'h1111_2222);
    ack = 1'b1;
    expect_ev(1'b0, 1'b0, 1'b1, 1'b0, cyc, 32'd0);
    step();
    ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    step();
    chk("b_idle", {30'd0, grant}, 32'd0);
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h204;
    step();
    ack = 1'b1;
    expect_ev(1'b1, 1'b0, 1'b0, 1'b0, cyc, 32'd0);
    step();
    ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    chk("b_tie2_grant", {30'd0, grant}, 32'd2);
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    step();
    chk("b_tie2_idle", {30'd0, grant}, 32'd0);

    // m1 three-beat locked cycle while m0 waits
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h400;
    step();
    chk("c_grant", {30'd0, grant}, 32'd2);
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h208;
    for (int b = 0; b < 3; b++) begin
      ack = 1'b1; s_dat = 32'hD000_0000 + b;
      expect_ev(1'b0, 1'b0, 1'b1, 1'b0, cyc, 32'hD000_0000 + b);
      step();
      ack = 1'b0; s_dat = '0; m1_stb = 1'b0;
      chk("c_locked", {30'd0, grant}, 32'd2);
      if (b < 2) begin
        step();
        m1_stb = 1'b1; m1_adr = m1_adr + 4;
        chk("c_locked_gap", {30'd0, grant}, 32'd2);
      end
    end
    m1_cyc = 1'b0;
    step();
    chk("c_to_m0", {30'd0, grant}, 32'd1);
    ack = 1'b1;
    expect_ev(1'b1, 1'b0, 1'b0, 1'b0, cyc, 32'd0);
    step();
    ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
    step();

    // Timeout: slave never ACKs, error after 15 and again after 31 cycles
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h500;
    step();
    g = cyc;
    chk("d_stb_o", {31'd0, stb_o}, 32'd1);
    expect_ev(1'b0, 1'b1, 1'b0, 1'b0, g + 15, 32'd0);
    expect_ev(1'b0, 1'b1, 1'b0, 1'b0, g + 31, 32'd0);
    for (int i = 0; i < 32; i++) step();
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step();

    // ACK exactly in the 15th wait cycle beats the timeout
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h600;
    step();
    for (int i = 0; i < 15; i++) step();
    ack = 1'b1; s_dat = 32'h1515_1515;
    expect_ev(1'b1, 1'b0, 1'b0, 1'b0, cyc, 32'h1515_1515);
    step();
    ack = 1'b0; s_dat = '0; m0_cyc = 1'b0; m0_stb = 1'b0;
    step();

    // Reset during an m1 write, timed to the would-be timeout cycle
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1; m1_adr = 32'h700;
    step();
    chk("f_grant", {30'd0, grant}, 32'd2);
    for (int i = 0; i < 15; i++) step();
    rst_n = 1'b0;
    step();
    chk("f_cyc_o", {31'd0, cyc_o}, 32'd0);
    chk("f_grant_rst", {30'd0, grant}, 32'd0);
    rst_n = 1'b1; m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    step();
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    step();
    chk("f_tie_firstwin", {30'd0, grant}, 32'd1);
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    step();
    step();
    chk("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end
endmodule
